// File: rtl/associative_memory_search.sv
// Nearest-prototype search over stored class hypervectors: streams CHUNK_WIDTH bits
// per cycle through an XOR/popcount datapath and reports the closest label and distance.

`ifndef HV_DIMENSION
`define HV_DIMENSION 1000
`endif

module associative_memory_search #(
    parameter int HV_DIMENSION = `HV_DIMENSION,
    parameter int CLASSES      = 5,
    parameter int CHUNK_WIDTH  = 100,
    localparam int LW = (CLASSES > 1) ? $clog2(CLASSES) : 1,
    localparam int DW = $clog2(HV_DIMENSION + 1)
) (
    input  logic                    Clk_CI,
    input  logic                    Rst_RBI,
    input  logic                    ProtoWrEn_SI,
    input  logic [LW-1:0]           ProtoAddr_DI,
    input  logic [0:HV_DIMENSION-1] ProtoData_DI,
    input  logic                    ValidIn_SI,
    output logic                    ReadyOut_SO,
    input  logic [0:HV_DIMENSION-1] HypervectorIn_DI,
    output logic                    ValidOut_SO,
    input  logic                    ReadyIn_SI,
    output logic [LW-1:0]           LabelOut_DO,
    output logic [DW-1:0]           DistanceOut_DO
);

    localparam int CHUNKS  = HV_DIMENSION / CHUNK_WIDTH;
    localparam int PW      = $clog2(CHUNK_WIDTH + 1);
    localparam int CW_BITS = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    if (HV_DIMENSION % CHUNK_WIDTH != 0) begin : g_bad_chunk_width
        $error("HV_DIMENSION must be an integer multiple of CHUNK_WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        DONE
    } state_e;

    state_e                    state_q, state_d;
    logic [0:HV_DIMENSION-1]   query_q, query_d;
    logic [0:HV_DIMENSION-1]   proto_q [CLASSES];
    logic [0:HV_DIMENSION-1]   proto_d [CLASSES];
    logic [LW-1:0]             class_q, class_d;
    logic [CW_BITS-1:0]        chunk_q, chunk_d;
    logic [DW-1:0]             acc_q, acc_d;
    logic [LW-1:0]             best_label_q, best_label_d;
    logic [DW-1:0]             best_dist_q, best_dist_d;
    logic [LW-1:0]             label_out_q, label_out_d;
    logic [DW-1:0]             dist_out_q, dist_out_d;

    // A write that coincides with a query accept is parked here until the search ends.
    logic                      pend_valid_q, pend_valid_d;
    logic [LW-1:0]             pend_addr_q, pend_addr_d;
    logic [0:HV_DIMENSION-1]   pend_data_q, pend_data_d;

    logic [CHUNK_WIDTH-1:0]    query_chunk;
    logic [CHUNK_WIDTH-1:0]    proto_chunk;
    logic [PW-1:0]             chunk_pc;
    logic [DW-1:0]             total;
    logic                      last_chunk;
    logic                      last_class;
    logic                      better;

    function automatic logic [PW-1:0] popcount(input logic [CHUNK_WIDTH-1:0] v);
        logic [PW-1:0] n;
        n = '0;
        for (int i = 0; i < CHUNK_WIDTH; i++) begin
            n = n + PW'(v[i]);
        end
        return n;
    endfunction

    always_comb begin
        query_chunk = query_q[int'(chunk_q) * CHUNK_WIDTH +: CHUNK_WIDTH];
        proto_chunk = proto_q[class_q][int'(chunk_q) * CHUNK_WIDTH +: CHUNK_WIDTH];
        chunk_pc    = popcount(query_chunk ^ proto_chunk);
        total       = acc_q + DW'(chunk_pc);
        last_chunk  = (chunk_q == CW_BITS'(CHUNKS - 1));
        last_class  = (class_q == LW'(CLASSES - 1));
        // Strict compare keeps the earlier (lower-index) class on ties.
        better      = (class_q == '0) || (total < best_dist_q);
    end

    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves a latch behind.
        state_d      = state_q;
        query_d      = query_q;
        proto_d      = proto_q;
        class_d      = class_q;
        chunk_d      = chunk_q;
        acc_d        = acc_q;
        best_label_d = best_label_q;
        best_dist_d  = best_dist_q;
        label_out_d  = label_out_q;
        dist_out_d   = dist_out_q;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        pend_data_d  = pend_data_q;

        case (state_q)
            IDLE: begin
                if (ProtoWrEn_SI) begin
                    if (ValidIn_SI) begin
                        if (ProtoAddr_DI < LW'(CLASSES)) begin
                            pend_valid_d = 1'b1;
                            pend_addr_d  = ProtoAddr_DI;
                            pend_data_d  = ProtoData_DI;
                        end
                    end else begin
                        for (int k = 0; k < CLASSES; k++) begin
                            if (ProtoAddr_DI == LW'(k)) proto_d[k] = ProtoData_DI;
                        end
                    end
                end
                if (ValidIn_SI) begin
                    query_d = HypervectorIn_DI;
                    class_d = '0;
                    chunk_d = '0;
                    acc_d   = '0;
                    state_d = COMPUTE;
                end
            end

            COMPUTE: begin
                acc_d   = total;
                chunk_d = chunk_q + 1'b1;
                if (last_chunk) begin
                    acc_d   = '0;
                    chunk_d = '0;
                    if (better) begin
                        best_label_d = class_q;
                        best_dist_d  = total;
                    end
                    if (last_class) begin
                        label_out_d = better ? class_q : best_label_q;
                        dist_out_d  = better ? total : best_dist_q;
                        state_d     = DONE;
                    end else begin
                        class_d = class_q + 1'b1;
                    end
                end
            end

            DONE: begin
                if (ReadyIn_SI) begin
                    state_d = IDLE;
                    if (pend_valid_q) begin
                        for (int k = 0; k < CLASSES; k++) begin
                            if (pend_addr_q == LW'(k)) proto_d[k] = pend_data_q;
                        end
                        pend_valid_d = 1'b0;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: the prototype store is reset like any other flop because a cleared
    // prototype set is observable behaviour after reset, not just an init value.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state_q      <= IDLE;
            query_q      <= '0;
            for (int k = 0; k < CLASSES; k++) proto_q[k] <= '0;
            class_q      <= '0;
            chunk_q      <= '0;
            acc_q        <= '0;
            best_label_q <= '0;
            best_dist_q  <= '0;
            label_out_q  <= '0;
            dist_out_q   <= '0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            state_q      <= state_d;
            query_q      <= query_d;
            proto_q      <= proto_d;
            class_q      <= class_d;
            chunk_q      <= chunk_d;
            acc_q        <= acc_d;
            best_label_q <= best_label_d;
            best_dist_q  <= best_dist_d;
            label_out_q  <= label_out_d;
            dist_out_q   <= dist_out_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
        end
    end

    assign ReadyOut_SO    = (state_q == IDLE);
    assign ValidOut_SO    = (state_q == DONE);
    assign LabelOut_DO    = label_out_q;
    assign DistanceOut_DO = dist_out_q;

endmodule

// File: doc/associative_memory_search.md
Name: associative_memory_search

Overview:
- Downstream consumer of the temporal accumulator's output hypervector.
- Holds one prototype hypervector per gesture class and accepts a query hypervector over a valid/ready handshake.
- Computes the Hamming distance from the query to every prototype, processing a fixed chunk of bits per cycle.
- Returns the label of the nearest class and its distance, then holds the result until the consumer takes it.

Parameters:
- HV_DIMENSION, `HV_DIMENSION: hypervector width in bits.
- CLASSES, 5: number of stored prototypes/labels.
- CHUNK_WIDTH, 100: bits compared per cycle. HV_DIMENSION must be an integer multiple of CHUNK_WIDTH; this is checked at elaboration.
- Derived values:
  - CHUNKS = HV_DIMENSION/CHUNK_WIDTH
  - LW = `ceilLog2(CLASSES)
  - DW = `ceilLog2(HV_DIMENSION+1)

Ports:
- Clk_CI  in  1  clock.
- Rst_RBI  in  1  reset, asynchronous, active-low.
- ProtoWrEn_SI  in  1  prototype write strobe.
- ProtoAddr_DI  in  LW  class index to write.
- ProtoData_DI  in  HV_DIMENSION  prototype value.
- ValidIn_SI  in  1  query valid.
- ReadyOut_SO  out  1  block can accept a query.
- HypervectorIn_DI  in  HV_DIMENSION  query (the temporal accumulator output).
- ValidOut_SO  out  1  result valid.
- ReadyIn_SI  in  1  consumer accepts result.
- LabelOut_DO  out  LW  index of the nearest prototype.
- DistanceOut_DO  out  DW  Hamming distance to the nearest prototype.

Behaviour:
- Reset (Rst_RBI low, takes effect immediately):
  - State goes to IDLE.
  - All prototypes, the query register, counters, accumulator, best label and best distance clear to 0.
  - LabelOut_DO=0, DistanceOut_DO=0, ValidOut_SO=0.
- Reset mid-search aborts the search with no output. After release the block is in IDLE with ReadyOut_SO=1.
- FSM states and transitions:
  - IDLE: ReadyOut_SO=1. When ValidIn_SI=1, the query is latched at the clock edge, class=0, chunk=0, accumulator=0, and state goes to COMPUTE.
  - COMPUTE: ReadyOut_SO=0. Each cycle, popcount(query chunk XOR prototype[class] chunk) is added to the accumulator, and chunk increments.
    - On the last chunk of a class: total = accumulator + popcount.
    - The best entry is replaced only if class==0 or total < best distance (strict), so ties resolve to the lower index.
    - Then the accumulator clears, chunk=0 and class increments.
    - After the last chunk of class CLASSES-1, state goes to DONE.
  - DONE: ValidOut_SO=1, and LabelOut_DO/DistanceOut_DO show the best entry and stay stable. When ReadyIn_SI=1, state goes to IDLE on that edge with ValidOut_SO=0.
- Latency: ValidOut_SO rises exactly CLASSES*CHUNKS cycles after the accept edge.
- Throughput: the next query is accepted no earlier than the cycle after the result handshake. There is no overlap.
- Chunk ordering: chunk c covers bit indices c*CHUNK_WIDTH .. c*CHUNK_WIDTH+CHUNK_WIDTH-1, using the same big-endian [0:N-1] indexing as the accumulator.
- Prototype writes:
  - Honoured only in IDLE. A write with ProtoWrEn_SI=1 stores ProtoData_DI at ProtoAddr_DI on the edge.
  - Writes in COMPUTE or DONE are dropped, so the prototypes stay consistent for the whole search.
  - ProtoAddr_DI >= CLASSES is ignored.
- A simultaneous write and query accept in IDLE are both honoured. The write is visible to the next search, not the one just accepted.
- Width rules:
  - Per-cycle popcount is ceilLog2(CHUNK_WIDTH+1) bits.
  - The accumulator and best distance are DW bits and cannot overflow, since the maximum is HV_DIMENSION.
- Outputs are registered. ReadyOut_SO and ValidOut_SO are decoded directly from the state register.

Test Plan:
1. Bench configuration HV_DIMENSION=16, CHUNK_WIDTH=4, CLASSES=3.
   - Stimulus: prototypes 0x0000, 0x00FF, 0xFFFF; query 0x00F0.
   - Required response: distances 4, 4, 12. ValidOut_SO rises exactly 12 cycles after accept. Label=0 (tie broken toward the lower index), Distance=4.
2. Same prototypes, query 0x00FE.
   - Required response: Label=1, Distance=1.
   - Query 0xFFFF: Label=2, Distance=0.
   - Query equal to the bitwise inverse of prototype 0 (0xFFFF against 0x0000 only): Distance=16 with no overflow.
3. Hold ReadyIn_SI=0 for 5 cycles while in DONE.
   - Required response: outputs stable, ValidOut_SO stays 1, ReadyOut_SO stays 0, and ValidIn_SI pulses are ignored.
   - Raise ReadyIn_SI: ValidOut_SO falls and ReadyOut_SO rises on the next edge.
4. Write prototype 1 = 0x0000 in the middle of COMPUTE.
   - Required response: the write is dropped and the current and next results still use 0x00FF.
   - The same write issued in IDLE, together with a query accept, takes effect only on the following search.
5. Deassert Rst_RBI between clock edges halfway through COMPUTE.
   - Required response: ValidOut_SO=0 and all outputs are 0 immediately, and all prototypes read back as 0.
   - After release: ReadyOut_SO=1, and a new query against all-zero prototypes gives Label=0, Distance=popcount(query).
6. Back-to-back queries with ValidIn_SI held at 1 and ReadyIn_SI held at 1.
   - Required response: one result every 12+2 cycles, results in order, none lost or duplicated.
